// File: rtl/dht11_if.sv
// Single-wire DHT11 pad plus data/status bundle shared by the emulator and its host.
// The bus has no valid/ready pair: busy is a level, frame_done and bus_error are one-cycle strobes.
interface dht11_if;
  logic       dht_data_in;
  logic       dht_data_oe;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       corrupt_chk;
  logic       busy;
  logic       frame_done;
  logic       bus_error;
  logic [2:0] state_dbg;

  modport master (
    output dht_data_in, hum_int, hum_dec, temp_int, temp_dec, corrupt_chk,
    input  dht_data_oe, busy, frame_done, bus_error, state_dbg
  );

  modport slave (
    input  dht_data_in, hum_int, hum_dec, temp_int, temp_dec, corrupt_chk,
    output dht_data_oe, busy, frame_done, bus_error, state_dbg
  );
endinterface

// File: rtl/dht11_emulator.sv
// Responder side of the DHT11 single-wire protocol: waits for a host start pulse, then
// drives the 80/80 us response and a 40-bit frame on an open-drain line (drive low or release).
module dht11_emulator #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_MIN_US  = 10000,
  parameter int RESP_DELAY_US = 30
) (
  input logic     clk,
  input logic     rst_n,
  dht11_if.slave  bus
);
  localparam int TICK_CYC = CLK_FREQ_HZ / 1_000_000;
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int CW       = 16;
  localparam logic [CW-1:0] START_MIN  = CW'(START_MIN_US);
  localparam logic [CW-1:0] RESP_DELAY = CW'(RESP_DELAY_US);
  localparam logic [CW-1:0] MASK_US    = CW'(2);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  pre;
  logic           us_tick;
  logic           sync_q1, line;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  phase_len;
  logic           phase_end;
  logic           contention;
  logic [39:0]    shreg;
  logic [5:0]     bit_cnt;
  logic [7:0]     sum;
  logic           oe, busy, frame_done, bus_error;

  // Free-running microsecond prescaler.
  assign us_tick = (pre == PW'(TICK_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst_n)        pre <= '0;
    else if (us_tick) pre <= '0;
    else              pre <= pre + PW'(1);
  end

  // Idle level of the pulled-up line is high, so the synchronizer resets to 1.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q1 <= 1'b1;
      line    <= 1'b1;
    end else begin
      sync_q1 <= bus.dht_data_in;
      line    <= sync_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)                               cnt <= '0;
    else if (state_nx != state)              cnt <= '0;
    else if (us_tick && (cnt != {CW{1'b1}})) cnt <= cnt + CW'(1);
  end

  always_comb begin
    phase_len = CW'(1);
    case (state)
      WAIT_RESP: phase_len = RESP_DELAY;
      RESP_LOW:  phase_len = CW'(80);
      RESP_HIGH: phase_len = CW'(80);
      BIT_LOW:   phase_len = CW'(50);
      BIT_HIGH:  phase_len = shreg[39] ? CW'(70) : CW'(26);
      END_LOW:   phase_len = CW'(50);
      default:   phase_len = CW'(1);
    endcase
  end

  // A phase ends on the tick that completes its length, so each phase is exact to one tick.
  assign phase_end  = us_tick && (cnt >= (phase_len - CW'(1)));
  // The first 2 us of a released phase are masked for synchronizer lag and pull-up rise.
  assign contention = !line && (cnt >= MASK_US);

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!line) state_nx = HOST_LOW;
      HOST_LOW:  if (line) state_nx = (cnt >= START_MIN) ? WAIT_RESP : IDLE;
      WAIT_RESP: if (contention) state_nx = HOST_LOW;
                 else if (phase_end) state_nx = RESP_LOW;
      RESP_LOW:  if (phase_end) state_nx = RESP_HIGH;
      RESP_HIGH: if (contention) state_nx = HOST_LOW;
                 else if (phase_end) state_nx = BIT_LOW;
      BIT_LOW:   if (phase_end) state_nx = BIT_HIGH;
      BIT_HIGH:  if (contention) state_nx = HOST_LOW;
                 else if (phase_end) state_nx = (bit_cnt == 6'd39) ? END_LOW : BIT_LOW;
      END_LOW:   if (phase_end) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    oe         = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    bus_error  = 1'b0;
    case (state)
      RESP_LOW, BIT_LOW: begin
        oe   = 1'b1;
        busy = 1'b1;
      end
      END_LOW: begin
        oe         = 1'b1;
        busy       = 1'b1;
        frame_done = phase_end;
      end
      WAIT_RESP, RESP_HIGH, BIT_HIGH: begin
        busy      = 1'b1;
        bus_error = contention;
      end
      default: ;
    endcase
  end

  // Frame snapshot at start accept; later byte changes cannot disturb the frame in flight.
  assign sum = bus.hum_int + bus.hum_dec + bus.temp_int + bus.temp_dec;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if ((state == HOST_LOW) && (state_nx == WAIT_RESP)) begin
      shreg   <= {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec,
                  sum ^ {8{bus.corrupt_chk}}};
      bit_cnt <= '0;
    end else if ((state == BIT_HIGH) && (state_nx == BIT_LOW)) begin
      shreg   <= {shreg[38:0], 1'b0};
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  assign bus.dht_data_oe = oe;
  assign bus.busy        = busy;
  assign bus.frame_done  = frame_done;
  assign bus.bus_error   = bus_error;
  assign bus.state_dbg   = state;
endmodule

// File: doc/dht11_emulator.md
Name: dht11_emulator

Overview:
- Behavioural-accurate DHT11 sensor model in RTL: the responder end of the single-wire protocol that dht11_reader initiates.
- Detects the host start pulse, then drives the 80/80 µs response and a 40-bit frame (hum_int, hum_dec, temp_int, temp_dec, checksum).
- Used on-board (loopback to dht11_reader) and in benches to exercise logic_controller, uart_string and LCD paths with programmable temperature/humidity.
- Line is open-drain: the block only ever drives low or releases; the pull-up is external.

Parameters:
- CLK_FREQ_HZ, 100_000_000, clk frequency; µs tick = CLK_FREQ_HZ/1_000_000 cycles.
- START_MIN_US, 10000, minimum host-low width accepted as a start request.
- RESP_DELAY_US, 30, wait after host release before the response.

Ports:
- clk  input  1  main clock, 100 MHz.
- rst_n  input  1  reset; synchronous, active-high (name kept per codebase).
- dht_data_in  input  1  sampled data line (pad input).
- dht_data_oe  output  1  1 = pull line low, 0 = release.
- hum_int  input  8  humidity integer byte.
- hum_dec  input  8  humidity decimal byte.
- temp_int  input  8  temperature integer byte.
- temp_dec  input  8  temperature decimal byte.
- corrupt_chk  input  1  1 = transmit inverted checksum (error injection).
- busy  output  1  high from start accept to end of frame.
- frame_done  output  1  one-cycle pulse when the final release occurs.
- bus_error  output  1  one-cycle pulse on contention abort.

Behaviour:
- Reset: dht_data_oe=0, busy=0, frame_done=0, bus_error=0; state IDLE; µs prescaler and counters cleared. A reset mid-frame releases the line on the next clk edge.
- Input path: 2-flop synchronizer on dht_data_in, giving 2 cycles of latency. All decisions use the synchronized value.
- Timing base: free-running prescaler pulses us_tick once per µs. State counters count us_ticks and clear on every state entry.
- IDLE: oe=0. Synchronized line low -> HOST_LOW.
- HOST_LOW: count µs while the line is low.
  - Line high with count < START_MIN_US -> IDLE; glitch ignored, no outputs.
  - Line high with count >= START_MIN_US -> WAIT_RESP.
  - On this transition: busy=1; snapshot the four data bytes and corrupt_chk into a 40-bit shift register.
  - checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, 8-bit wrap. It is bitwise inverted if corrupt_chk=1.
- WAIT_RESP: oe=0 for RESP_DELAY_US -> RESP_LOW.
- RESP_LOW: oe=1 for 80 µs -> RESP_HIGH.
- RESP_HIGH: oe=0 for 80 µs -> BIT_LOW.
- BIT_LOW: oe=1 for 50 µs -> BIT_HIGH.
- BIT_HIGH: oe=0 for 26 µs if the current bit is 0, 70 µs if it is 1.
  - Bits go out MSB-first, byte order hum_int, hum_dec, temp_int, temp_dec, checksum.
  - Bit counter 0..39. After bit 39 -> END_LOW; otherwise shift and -> BIT_LOW.
- END_LOW: oe=1 for 50 µs. Then oe=0, frame_done pulse, busy=0 -> IDLE.
- Snapshot rule: input bytes changing while busy=1 have no effect on the current frame.
- Contention: in WAIT_RESP, RESP_HIGH or BIT_HIGH, a synchronized low seen after the first 2 µs of the phase means the host is driving.
  - Response: oe=0, bus_error pulse, busy=0 -> HOST_LOW with its counter restarted. A long pulse therefore re-arms a start.
  - The first 2 µs are masked to cover synchronizer lag and pull-up rise.
- The block never drives the line while in IDLE or HOST_LOW.
- Timing tolerance: every phase is exact to ±1 µs tick (one prescaler period of quantization at entry).

Test Plan:
- Normal frame: host low 18 ms, release. Bytes hum_int=0x32, hum_dec=0x00, temp_int=0x19, temp_dec=0x00.
  - Required: oe rises 30±1 µs after release; 80/80 µs response; 40 bits decode to 32 00 19 00 4B.
  - Required: each 0-bit high is 26 µs, each 1-bit high is 70 µs; frame_done pulses once; busy low afterwards.
- Short start: host low 500 µs, release -> oe stays 0, busy stays 0 for 5 ms. A following 18 ms pulse yields a normal frame.
- Checksum wrap and corrupt: bytes FF, FF, FF, 03 -> checksum 0x00. Same bytes with corrupt_chk=1 -> 0xFF. A frame through dht11_reader with the bad checksum must not update its outputs.
- Snapshot: change temp_int 0x19→0x1E during bit 10 -> frame still carries 0x19 and checksum 0x4B. The next frame carries 0x1E and checksum 0x50.
- Contention: bench drives the line low for 10 µs during RESP_HIGH -> bus_error pulse, oe=0 within 3 cycles of the synchronized low, busy=0, no frame_done.
- Reset mid-frame: assert rst_n for 1 cycle during bit 20 while oe=1 -> oe=0 on the next edge, busy=0. A new 18 ms start produces a complete correct frame.
